mem_access: RTL



---
 rtl/mem_access.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM-stage data-memory controller: turns a load/store into one req/ack bus transfer and returns aligned, extended load data.
// Latency: 3 cycles minimum (IDLE, REQ with ack, DONE). Each extra wait adds 1 cycle. A timeout takes P_TIMEOUT+2 cycles.
// Backpressure: o_stall holds the pipeline from request until DONE. The bus is held in REQ until i_bus_ack or timeout.
// Optional feature: define MEM_ALIGNCHK_EN to reject misaligned half/word accesses with o_bus_err and no bus request.
module mem_access #(
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_con_Mmemread,
    input  logic        i_con_Mmemwrite,
    input  logic [1:0]  i_con_Msize,
    input  logic        i_con_Munsigned,
    input  logic [31:0] i_data_alures,
    input  logic [31:0] i_data_wrdata,
    output logic [31:0] o_data_memout,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, result_q;
    logic [3:0]  be_q;
    logic [1:0]  lane_q, size_q;
    logic        uns_q, we_q, err_q;
    logic [15:0] cnt_q;

    logic        start, misalign, timeout_hit, stall_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ext_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign start       = (state_q == IDLE) && (i_con_Mmemread || i_con_Mmemwrite);
    // Ack has priority: a timeout only counts when no ack arrives in that cycle.
    assign timeout_hit = (state_q == REQ) && !i_bus_ack && (cnt_q == TO_LAST);

`ifdef MEM_ALIGNCHK_EN
    // Half needs addr[0]=0; word (and size 11) needs addr[1:0]=0.
    always_comb begin
        misalign = 1'b0;
        if (i_con_Msize == 2'b01)
            misalign = i_data_alures[0];
        else if (i_con_Msize[1])
            misalign = (i_data_alures[1:0] != 2'b00);
    end
`else
    assign misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = i_data_wrdata;
        case (i_con_Msize)
            2'b00: begin
                be_d    = 4'b0001 << i_data_alures[1:0];
                wdata_d = {4{i_data_wrdata[7:0]}};
            end
            2'b01: begin
                be_d    = i_data_alures[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{i_data_wrdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = i_data_wrdata;
            end
        endcase
    end

    // Select the addressed lane from read data and extend it to 32 bits.
    always_comb begin
        ld_half = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (lane_q)
            2'd0:    ld_byte = i_bus_rdata[7:0];
            2'd1:    ld_byte = i_bus_rdata[15:8];
            2'd2:    ld_byte = i_bus_rdata[23:16];
            default: ld_byte = i_bus_rdata[31:24];
        endcase
        case (size_q)
            2'b00:   ext_d = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ext_d = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ext_d = i_bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and stall decode.
    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_d = 1'b1;
                    state_d = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                stall_d = 1'b1;
                if (i_bus_ack || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates stall directly so it drops without waiting for a clock.
    assign o_stall   = stall_d && i_nrst;
    assign o_bus_req = (state_q == REQ);
    assign o_bus_we  = (state_q == REQ) && we_q;

    // Access registers, wait counter, result and error pulse.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 16'h0;
            result_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (start) begin
                addr_q  <= {i_data_alures[31:2], 2'b00};
                lane_q  <= i_data_alures[1:0];
                size_q  <= i_con_Msize;
                uns_q   <= i_con_Munsigned;
                we_q    <= i_con_Mmemwrite;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                cnt_q   <= 16'h0;
                if (misalign) begin
                    result_q <= 32'h0;
                    err_q    <= 1'b1;
                end
            end else if (state_q == REQ) begin
                if (i_bus_ack) begin
                    if (!we_q) result_q <= ext_d;
                end else if (timeout_hit) begin
                    result_q <= 32'h0;
                    err_q    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    assign o_bus_addr    = addr_q;
    assign o_bus_wdata   = wdata_q;
    assign o_bus_be      = be_q;
    assign o_data_memout = result_q;
    assign o_bus_err     = err_q;

endmodule
